mdu_iter: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS CPU54 core.
- Sits directly downstream of the register file. It consumes the rs and rt read-port values and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Holds HI/LO for MFHI/MFLO. The controller reads HI/LO and writes them back to the register file through the rd path.
- One shared shift datapath; busy/done handshake so the controller can stall.

---
 rtl/mdu_iter.sv | 176 +++++++++++++++++
 tb/tb_mdu_iter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mdu_iter : iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with HI/LO regs      |
// | Rev 1.0  : initial release                                                   |
// +-----------------------------------------------------------------------------+
module mdu_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int            CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);
   localparam logic [2:0]    c_op_mthi = 3'd4;
   localparam logic [2:0]    c_op_mtlo = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opb;
   logic               r_is_div;
   logic               r_sign_q;
   logic               r_sign_r;
   logic               r_divz;
   logic               r_done;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic               w_start_arith;
   logic               w_signed_op;
   logic [WIDTH-1:0]   w_rs_v;
   logic [WIDTH-1:0]   w_rt_v;
   logic [WIDTH:0]     w_madd;
   logic [WIDTH:0]     w_dshift;
   logic [WIDTH:0]     w_dtrial;
   logic [2*WIDTH-1:0] w_acc_nxt;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;
   logic [WIDTH-1:0]   w_fix_hi;
   logic [WIDTH-1:0]   w_fix_lo;

   assign w_start_arith = start && (r_state == S_IDLE) && !op[2];
   assign w_signed_op   = !op[0];
   assign w_rs_v        = (w_signed_op && rs[WIDTH-1]) ? (~rs + 1'b1) : rs;
   assign w_rt_v        = (w_signed_op && rt[WIDTH-1]) ? (~rt + 1'b1) : rt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start_arith) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (r_cnt == c_last) begin
               w_state_nxt = S_FIX;
            end
         end
         S_FIX: begin
            busy        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Multiply: {upper, multiplier} shifts right; divide: {rem, quo} shifts left.
   always_comb begin
      w_madd    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
      w_dshift  = r_acc[2*WIDTH-1:WIDTH-1];
      w_dtrial  = w_dshift - {1'b0, r_opb};
      w_acc_nxt = {w_madd, r_acc[WIDTH-1:1]};
      if (r_is_div) begin
         if (w_dtrial[WIDTH]) begin
            w_acc_nxt = {w_dshift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
         end else begin
            w_acc_nxt = {w_dtrial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
         end
      end
   end

   // With a zero divisor the remainder ends equal to |rs|, so re-signing it yields rs.
   always_comb begin
      w_prod   = r_sign_q ? (~r_acc + 1'b1) : r_acc;
      w_quo    = r_acc[WIDTH-1:0];
      w_rem    = r_acc[2*WIDTH-1:WIDTH];
      w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod[WIDTH-1:0];
      if (r_is_div) begin
         w_fix_hi = r_sign_r ? (~w_rem + 1'b1) : w_rem;
         if (r_divz) begin
            w_fix_lo = {WIDTH{1'b1}};
         end else begin
            w_fix_lo = r_sign_q ? (~w_quo + 1'b1) : w_quo;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opb    <= '0;
         r_is_div <= 1'b0;
         r_sign_q <= 1'b0;
         r_sign_r <= 1'b0;
         r_divz   <= 1'b0;
         r_done   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start_arith) begin
                  r_cnt    <= '0;
                  r_is_div <= op[1];
                  r_divz   <= (rt == '0);
                  r_sign_q <= w_signed_op && (rs[WIDTH-1] ^ rt[WIDTH-1]);
                  r_sign_r <= w_signed_op && rs[WIDTH-1];
                  r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_rs_v : w_rt_v)};
                  r_opb    <= op[1] ? w_rt_v : w_rs_v;
               end else if (start && (op == c_op_mthi)) begin
                  r_hi <= rs;
               end else if (start && (op == c_op_mtlo)) begin
                  r_lo <= rs;
               end
            end
            S_RUN: begin
               r_acc <= w_acc_nxt;
               r_cnt <= r_cnt + CW'(1);
            end
            S_FIX: begin
               r_hi   <= w_fix_hi;
               r_lo   <= w_fix_lo;
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_mdu_iter : directed self-checking bench for mdu_iter                      |
// | Rev 1.0     : initial release                                                |
// +-----------------------------------------------------------------------------+
module tb_mdu_iter;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs;
   logic [31:0] rt;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   mdu_iter #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .rs    (rs),
      .rt    (rt),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      rs    = a;
      rt    = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts edges from the accepting edge (inclusive) up to the one raising done.
   task automatic wait_done(output int edges, output int busy_cycles, output bit seen);
      edges       = 1;
      busy_cycles = 0;
      seen        = 1'b0;
      for (int n = 0; n < 100; n++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) busy_cycles++;
         @(negedge clk);
         edges++;
      end
   endtask

   task automatic test_reset();
      checks++; if (hi !== 32'h0)  begin errors++; $display("FAIL reset_hi: got %h expected %h", hi, 32'h0); end
      checks++; if (lo !== 32'h0)  begin errors++; $display("FAIL reset_lo: got %h expected %h", lo, 32'h0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
   endtask

   task automatic test_mult();
      int e, bc; bit s;
      launch(3'd0, 32'd7, 32'hFFFFFFFD);
      wait_done(e, bc, s);
      checks++; if (s !== 1'b1) begin errors++; $display("FAIL mult_done: got %b expected 1", s); end
      checks++; if (e != 34)    begin errors++; $display("FAIL mult_latency: got %0d expected 34", e); end
      checks++; if (bc != 33)   begin errors++; $display("FAIL mult_busy_cycles: got %0d expected 33", bc); end
      checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h expected %h", hi, 32'hFFFFFFFF); end
      checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo: got %h expected %h", lo, 32'hFFFFFFEB); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b expected 0", done); end
   endtask

   task automatic test_multu();
      int e, bc; bit s;
      launch(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(e, bc, s);
      checks++; if (s !== 1'b1) begin errors++; $display("FAIL multu_done: got %b expected 1", s); end
      checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h expected %h", hi, 32'hFFFFFFFE); end
      checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h expected %h", lo, 32'h1); end
   endtask

   task automatic test_div();
      int e, bc; bit s;
      launch(3'd2, 32'hFFFFFFF9, 32'd2);
      wait_done(e, bc, s);
      checks++; if (s !== 1'b1) begin errors++; $display("FAIL div_done: got %b expected 1", s); end
      checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h expected %h", lo, 32'hFFFFFFFD); end
      checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h expected %h", hi, 32'hFFFFFFFF); end
      launch(3'd2, 32'h80000000, 32'hFFFFFFFF);
      wait_done(e, bc, s);
      checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo: got %h expected %h", lo, 32'h80000000); end
      checks++; if (hi !== 32'h0)        begin errors++; $display("FAIL div_ovf_hi: got %h expected %h", hi, 32'h0); end
      launch(3'd3, 32'd100, 32'd7);
      wait_done(e, bc, s);
      checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h expected %h", lo, 32'd14); end
      checks++; if (hi !== 32'd2)  begin errors++; $display("FAIL divu_hi: got %h expected %h", hi, 32'd2); end
   endtask

   task automatic test_divzero();
      int e, bc; bit s;
      launch(3'd3, 32'h12345678, 32'h0);
      wait_done(e, bc, s);
      checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL divu0_hi: got %h expected %h", hi, 32'h12345678); end
      checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu0_lo: got %h expected %h", lo, 32'hFFFFFFFF); end
      launch(3'd2, 32'hFFFFFFF0, 32'h0);
      wait_done(e, bc, s);
      checks++; if (hi !== 32'hFFFFFFF0) begin errors++; $display("FAIL div0_hi: got %h expected %h", hi, 32'hFFFFFFF0); end
      checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_lo: got %h expected %h", lo, 32'hFFFFFFFF); end
   endtask

   task automatic test_mthi_mtlo();
      int e, bc; bit s;
      launch(3'd4, 32'hA5A5A5A5, 32'h0);
      checks++; if (hi !== 32'hA5A5A5A5) begin errors++; $display("FAIL mthi_hi: got %h expected %h", hi, 32'hA5A5A5A5); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL mthi_done: got %b expected 0", done); end
      launch(3'd5, 32'h5A5A5A5A, 32'h0);
      checks++; if (lo !== 32'h5A5A5A5A) begin errors++; $display("FAIL mtlo_lo: got %h expected %h", lo, 32'h5A5A5A5A); end
      checks++; if (hi !== 32'hA5A5A5A5) begin errors++; $display("FAIL mtlo_hi_kept: got %h expected %h", hi, 32'hA5A5A5A5); end
      launch(3'd6, 32'h11111111, 32'h22222222);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nop_busy: got %b expected 0", busy); end
      checks++; if (lo !== 32'h5A5A5A5A) begin errors++; $display("FAIL nop_lo: got %h expected %h", lo, 32'h5A5A5A5A); end
      // MTLO while a MULT is running must be dropped
      launch(3'd0, 32'd7, 32'hFFFFFFFD);
      start = 1'b1; op = 3'd5; rs = 32'hDEADBEEF; rt = 32'h0;
      @(negedge clk);
      start = 1'b0;
      checks++; if (lo !== 32'h5A5A5A5A) begin errors++; $display("FAIL busy_mtlo_hold: got %h expected %h", lo, 32'h5A5A5A5A); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_mtlo_busy: got %b expected 1", busy); end
      wait_done(e, bc, s);
      checks++; if (s !== 1'b1) begin errors++; $display("FAIL busy_mtlo_done: got %b expected 1", s); end
      checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL busy_mtlo_lo: got %h expected %h", lo, 32'hFFFFFFEB); end
      checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL busy_mtlo_hi: got %h expected %h", hi, 32'hFFFFFFFF); end
   endtask

   task automatic test_abort();
      int e, bc; bit s;
      bit saw_done;
      launch(3'd1, 32'd3, 32'd5);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (hi !== 32'h0)  begin errors++; $display("FAIL abort_hi: got %h expected %h", hi, 32'h0); end
      checks++; if (lo !== 32'h0)  begin errors++; $display("FAIL abort_lo: got %h expected %h", lo, 32'h0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
      @(negedge clk);
      rst_n = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) saw_done = 1'b1;
      end
      checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b expected 0", saw_done); end
      launch(3'd1, 32'd3, 32'd5);
      wait_done(e, bc, s);
      checks++; if (s !== 1'b1)   begin errors++; $display("FAIL abort_rerun_done: got %b expected 1", s); end
      checks++; if (e != 34)      begin errors++; $display("FAIL abort_rerun_latency: got %0d expected 34", e); end
      checks++; if (lo !== 32'd15) begin errors++; $display("FAIL abort_rerun_lo: got %h expected %h", lo, 32'd15); end
      checks++; if (hi !== 32'd0)  begin errors++; $display("FAIL abort_rerun_hi: got %h expected %h", hi, 32'd0); end
   endtask

   task automatic test_back_to_back();
      int e, bc; bit s;
      launch(3'd3, 32'd100, 32'd7);
      wait_done(e, bc, s);
      checks++; if (s !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b expected 1", s); end
      // Issue the next op in the done cycle itself
      start = 1'b1; op = 3'd1; rs = 32'h00010000; rt = 32'h00010000;
      @(negedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_busy: got %b expected 1", busy); end
      checks++; if (lo !== 32'd14) begin errors++; $display("FAIL b2b_lo_hold: got %h expected %h", lo, 32'd14); end
      checks++; if (hi !== 32'd2)  begin errors++; $display("FAIL b2b_hi_hold: got %h expected %h", hi, 32'd2); end
      wait_done(e, bc, s);
      checks++; if (s !== 1'b1)  begin errors++; $display("FAIL b2b_done: got %b expected 1", s); end
      checks++; if (e != 34)     begin errors++; $display("FAIL b2b_latency: got %0d expected 34", e); end
      checks++; if (hi !== 32'd1) begin errors++; $display("FAIL b2b_hi: got %h expected %h", hi, 32'd1); end
      checks++; if (lo !== 32'd0) begin errors++; $display("FAIL b2b_lo: got %h expected %h", lo, 32'd0); end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      op    = 3'd0;
      rs    = 32'h0;
      rt    = 32'h0;
      repeat (2) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      test_mult();
      test_multu();
      test_div();
      test_divzero();
      test_mthi_mtlo();
      test_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
